// File: rtl/rename_map.sv
// rename_map: 4-wide register rename stage feeding the RN/DS pipeline register.
//
// Maps 32 architectural registers onto 64 physical registers. Three pieces of
// state do the work:
//   - a speculative RAT, updated as groups rename;
//   - a committed RAT, updated by the commit port;
//   - a 32-entry circular free list. Its three 6-bit pointers (spec_head,
//     commit_head, tail) each carry a wrap bit above the 5-bit index.
// r0 is hardwired to phys 0 and is never renamed.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   flush                     recovery: spec state <= committed state
//   Stall                     downstream RN_DS register is holding
//   Dec_Valid/Dec_Wen [3:0]   per-slot valid / writes Rdst (slot 0 oldest)
//   Dec_Src1/Src2/Rdst [19:0] 5-bit arch fields, slot k at [5k+4:5k]
//   RE_RSrc1/RSrc2 [23:0]     physical sources, slot k at [6k+5:6k]
//   RE_Phydst/RE_OldPhy       new destination phys / previous mapping
//   RN_Valid [3:0]            slots actually renamed this cycle
//   Rename_Stall              group cannot be renamed this cycle
//   Cm_* (Valid/Wen/Rdst/Phydst/OldPhy) in-order commit port, slot 0 oldest
//
// Handshake: a decode group is offered by raising Dec_Valid. It is consumed on
// a rising edge only when Rename_Stall=0 and flush=0; RN_Valid mirrors exactly
// the slots consumed on that edge. While Rename_Stall=1, decode must hold the
// group unchanged. The commit port has no back-pressure: every valid commit
// group is absorbed on the edge it is presented.
module rename_map (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        Stall,
    input  logic [3:0]  Dec_Valid,
    input  logic [3:0]  Dec_Wen,
    input  logic [19:0] Dec_Src1,
    input  logic [19:0] Dec_Src2,
    input  logic [19:0] Dec_Rdst,
    output logic [23:0] RE_RSrc1,
    output logic [23:0] RE_RSrc2,
    output logic [23:0] RE_Phydst,
    output logic [23:0] RE_OldPhy,
    output logic [3:0]  RN_Valid,
    output logic        Rename_Stall,
    input  logic [3:0]  Cm_Valid,
    input  logic [3:0]  Cm_Wen,
    input  logic [19:0] Cm_Rdst,
    input  logic [23:0] Cm_Phydst,
    input  logic [23:0] Cm_OldPhy
);

    logic [5:0] spec_rat_q [32];
    logic [5:0] spec_rat_d [32];
    logic [5:0] cm_rat_q   [32];
    logic [5:0] cm_rat_d   [32];
    logic [5:0] fl_q       [32];
    logic [5:0] fl_d       [32];
    logic [5:0] spec_head_q, spec_head_d;
    logic [5:0] cm_head_q,   cm_head_d;
    logic [5:0] tail_q,      tail_d;

    logic [5:0] count;
    logic [3:0] wr;
    logic [2:0] need;
    logic [2:0] ofs;
    logic [4:0] fl_idx;
    logic [5:0] alloc [4];
    logic       fire;

    logic [4:0] src1, src2, dst;
    logic [5:0] p1, p2, po;

    logic       cm_go;
    logic [2:0] cm_n;
    logic [4:0] cm_idx;
    logic [4:0] cm_rd;

    // Occupancy; the wrap bit makes 32 (full) distinct from 0 (empty).
    assign count        = tail_q - spec_head_q;
    assign Rename_Stall = Stall | ({3'b000, need} > count);
    assign fire         = (|Dec_Valid) & ~Rename_Stall & ~flush;
    assign RN_Valid     = fire ? Dec_Valid : 4'b0000;

    // Writer detection and free-list allocation: the j-th writer in slot
    // order takes the entry j past spec_head.
    always_comb begin
        wr     = '0;
        ofs    = '0;
        fl_idx = '0;
        for (int k = 0; k < 4; k++) begin
            wr[k]    = Dec_Valid[k] & Dec_Wen[k] & (Dec_Rdst[5*k +: 5] != 5'd0);
            fl_idx   = spec_head_q[4:0] + {2'b00, ofs};
            alloc[k] = fl_q[fl_idx];
            if (wr[k]) ofs = ofs + 3'd1;
        end
        need = ofs;
    end

    // Source / old-mapping lookup with intra-group bypass. Scanning older
    // slots in ascending order lets the youngest older writer win.
    always_comb begin
        RE_RSrc1  = '0;
        RE_RSrc2  = '0;
        RE_Phydst = '0;
        RE_OldPhy = '0;
        src1 = '0;
        src2 = '0;
        dst  = '0;
        p1   = '0;
        p2   = '0;
        po   = '0;
        for (int k = 0; k < 4; k++) begin
            src1 = Dec_Src1[5*k +: 5];
            src2 = Dec_Src2[5*k +: 5];
            dst  = Dec_Rdst[5*k +: 5];
            p1   = spec_rat_q[src1];
            p2   = spec_rat_q[src2];
            po   = spec_rat_q[dst];
            for (int j = 0; j < 4; j++) begin
                if (j < k && wr[j]) begin
                    if (Dec_Rdst[5*j +: 5] == src1) p1 = alloc[j];
                    if (Dec_Rdst[5*j +: 5] == src2) p2 = alloc[j];
                    if (Dec_Rdst[5*j +: 5] == dst)  po = alloc[j];
                end
            end
            if (src1 == 5'd0) p1 = 6'd0;
            if (src2 == 5'd0) p2 = 6'd0;
            if (Dec_Valid[k]) begin
                RE_RSrc1[6*k +: 6] = p1;
                RE_RSrc2[6*k +: 6] = p2;
            end
            if (wr[k]) begin
                RE_Phydst[6*k +: 6] = alloc[k];
                RE_OldPhy[6*k +: 6] = po;
            end
        end
    end

    // Next state. Commit is applied first so that a flush on the same edge
    // restores from the committed RAT including those commits.
    always_comb begin
        cm_rat_d   = cm_rat_q;
        fl_d       = fl_q;
        spec_rat_d = spec_rat_q;
        cm_go      = 1'b1;
        cm_n       = '0;
        cm_idx     = '0;
        cm_rd      = '0;
        for (int k = 0; k < 4; k++) begin
            // Commit is contiguous from slot 0; the first gap ends the group.
            cm_go = cm_go & Cm_Valid[k];
            cm_rd = Cm_Rdst[5*k +: 5];
            if (cm_go && Cm_Wen[k] && (cm_rd != 5'd0)) begin
                cm_rat_d[cm_rd] = Cm_Phydst[6*k +: 6];
                cm_idx          = tail_q[4:0] + {2'b00, cm_n};
                fl_d[cm_idx]    = Cm_OldPhy[6*k +: 6];
                cm_n            = cm_n + 3'd1;
            end
        end
        tail_d      = tail_q + {3'b000, cm_n};
        cm_head_d   = cm_head_q + {3'b000, cm_n};
        spec_head_d = spec_head_q;
        if (flush) begin
            spec_rat_d  = cm_rat_d;
            spec_head_d = cm_head_d;
        end else if (fire) begin
            for (int k = 0; k < 4; k++) begin
                if (wr[k]) spec_rat_d[Dec_Rdst[5*k +: 5]] = alloc[k];
            end
            spec_head_d = spec_head_q + {3'b000, need};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                spec_rat_q[r] <= 6'(r);
                cm_rat_q[r]   <= 6'(r);
                fl_q[r]       <= 6'(32 + r);
            end
            spec_head_q <= 6'd0;
            cm_head_q   <= 6'd0;
            // Index 0 with the wrap bit set: a full list of 32 free entries.
            tail_q      <= 6'd32;
        end else begin
            spec_rat_q  <= spec_rat_d;
            cm_rat_q    <= cm_rat_d;
            fl_q        <= fl_d;
            spec_head_q <= spec_head_d;
            cm_head_q   <= cm_head_d;
            tail_q      <= tail_d;
        end
    end

endmodule
